// File: rtl/mono_video_pkg.sv
// Shared types and helpers for the monochrome video colouriser: scanline modes,
// the 6-bit reference tint palette and the per-channel scanline shade function.
package mono_video_pkg;

  typedef enum logic [1:0] {
    SL_NONE = 2'd0,
    SL_25   = 2'd1,
    SL_50   = 2'd2,
    SL_75   = 2'd3
  } scan_mode_e;

  localparam int SHADE_W    = 16;
  localparam int BASE_DEPTH = 6;

  // Reference palette in 6-bit {R,G,B}; entries past the named tints are white.
  function automatic logic [3*BASE_DEPTH-1:0] default_pal6(input int idx);
    case (idx)
      0:       return {6'h3F, 6'h3F, 6'h3F};
      1:       return {6'h0D, 6'h3F, 6'h0D};
      2:       return {6'h3F, 6'h33, 6'h00};
      3:       return {6'h10, 6'h3F, 6'h29};
      default: return {6'h3F, 6'h3F, 6'h3F};
    endcase
  endfunction

  function automatic logic [SHADE_W-1:0] shade(input logic [SHADE_W-1:0] v,
                                               input scan_mode_e        mode);
    case (mode)
      SL_25:   return v - (v >> 2);
      SL_50:   return v >> 1;
      SL_75:   return v >> 2;
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/mono_palette_ram.sv
// Tint palette register file: reset-loaded defaults, one write port, async read.
// Zero read latency; writes take effect on the next clock, no backpressure.
module mono_palette_ram
  import mono_video_pkg::*;
#(
  parameter int NUM_TINTS   = 4,
  parameter int COLOR_DEPTH = 6,
  parameter int TSEL_W      = 2
) (
  input  logic                     clk_sys,
  input  logic                     reset_in,
  input  logic                     wr,
  input  logic [TSEL_W-1:0]        waddr,
  input  logic [3*COLOR_DEPTH-1:0] wdata,
  input  logic [TSEL_W-1:0]        raddr,
  output logic [3*COLOR_DEPTH-1:0] rdata
);

  localparam int ENTRY_W = 3 * COLOR_DEPTH;
  localparam int UP_SH   = (COLOR_DEPTH >= BASE_DEPTH) ? COLOR_DEPTH - BASE_DEPTH : 0;
  localparam int DN_SH   = (COLOR_DEPTH <  BASE_DEPTH) ? BASE_DEPTH - COLOR_DEPTH : 0;

  // Left-justify (or truncate) a 6-bit reference channel to COLOR_DEPTH bits.
  function automatic logic [COLOR_DEPTH-1:0] fit(input logic [BASE_DEPTH-1:0] v6);
    logic [31:0] w;
    w = (32'(v6) << UP_SH) >> DN_SH;
    return w[COLOR_DEPTH-1:0];
  endfunction

  function automatic logic [ENTRY_W-1:0] default_entry(input int idx);
    logic [3*BASE_DEPTH-1:0] p;
    p = default_pal6(idx);
    return {fit(p[17:12]), fit(p[11:6]), fit(p[5:0])};
  endfunction

  logic [ENTRY_W-1:0] mem [NUM_TINTS];

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_TINTS; i++) mem[i] <= default_entry(i);
    end else if (wr && (int'(waddr) < NUM_TINTS)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < NUM_TINTS) ? mem[raddr] : '0;

endmodule

// File: rtl/mono_video_colorizer.sv
// Tints an N-bit intensity stream via a programmable palette, adds scanline darkening.
// Latency 2 ce_pix; holds when ce_pix=0 (no backpressure). MONO_VIDEO_AFTERGLOW_EN adds glow.
module mono_video_colorizer
  import mono_video_pkg::*;
#(
  parameter int IN_BITS     = 1,
  parameter int COLOR_DEPTH = 6,
  parameter int NUM_TINTS   = 4,
  parameter int DECAY_SHIFT = 3,
  localparam int TSEL_W     = (NUM_TINTS > 1) ? $clog2(NUM_TINTS) : 1
) (
  input  logic                     clk_sys,
  input  logic                     reset_in,
  input  logic                     ce_pix,
  input  logic [IN_BITS-1:0]       pix_in,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic                     blank_in,
  input  logic [TSEL_W-1:0]        tint_sel,
  input  logic [1:0]               scanlines,
  input  logic                     pal_wr,
  input  logic [TSEL_W-1:0]        pal_addr,
  input  logic [3*COLOR_DEPTH-1:0] pal_data,
  output logic [COLOR_DEPTH-1:0]   r_out,
  output logic [COLOR_DEPTH-1:0]   g_out,
  output logic [COLOR_DEPTH-1:0]   b_out,
  output logic                     hs_out,
  output logic                     vs_out,
  output logic                     blank_out
);

  localparam int CD = COLOR_DEPTH;
  localparam int PW = COLOR_DEPTH + IN_BITS;

  if (IN_BITS < 1 || CD < 1 || CD > SHADE_W || DECAY_SHIFT < 0) begin : g_bad_cfg
    $error("mono_video_colorizer: unsupported parameter combination");
  end

  logic [IN_BITS-1:0] s1_pix;
  logic               s1_hs, s1_vs, s1_blank;
  logic [TSEL_W-1:0]  active_tint;
  logic               line_odd;
  logic [3*CD-1:0]    pal_rdata;
  logic               vs_rise, hs_rise;

  assign vs_rise = vs_in & ~s1_vs;
  assign hs_rise = hs_in & ~s1_hs;

  // Tint and line parity move only on ce_pix edges; vsync takes priority over hsync.
  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      s1_pix      <= '0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_blank    <= 1'b0;
      active_tint <= '0;
      line_odd    <= 1'b0;
    end else if (ce_pix) begin
      s1_pix   <= pix_in;
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
      s1_blank <= blank_in;
      if (vs_rise) begin
        active_tint <= tint_sel;
        line_odd    <= 1'b0;
      end else if (hs_rise) begin
        line_odd <= ~line_odd;
      end
    end
  end

  mono_palette_ram #(
    .NUM_TINTS  (NUM_TINTS),
    .COLOR_DEPTH(CD),
    .TSEL_W     (TSEL_W)
  ) u_palette (
    .clk_sys (clk_sys),
    .reset_in(reset_in),
    .wr      (pal_wr),
    .waddr   (pal_addr),
    .wdata   (pal_data),
    .raddr   (active_tint),
    .rdata   (pal_rdata)
  );

  logic [CD-1:0] pal_ch   [3];
  logic [PW-1:0] prod     [3];
  logic [CD-1:0] scaled   [3];
  logic [CD-1:0] chan_val [3];
  logic [CD-1:0] color_d  [3];
  scan_mode_e    line_mode;

  always_comb begin
    line_mode = line_odd ? scan_mode_e'(scanlines) : SL_NONE;
    for (int c = 0; c < 3; c++) begin
      pal_ch[c] = pal_rdata[(2-c)*CD +: CD];
      prod[c]   = PW'(pal_ch[c]) * PW'(s1_pix);
      scaled[c] = (&s1_pix) ? pal_ch[c] : CD'(prod[c] >> IN_BITS);
    end
  end

`ifdef MONO_VIDEO_AFTERGLOW_EN
  logic [CD-1:0] glow_q [3];
  logic [CD:0]   decay  [3];
  logic          glow_clr;

  // Glow tracks the brighter of the new value and a decaying copy of itself.
  always_comb begin
    glow_clr = s1_blank | (s1_hs & ~hs_out);
    for (int c = 0; c < 3; c++) begin
      decay[c] = {1'b0, glow_q[c]} - {1'b0, glow_q[c] >> DECAY_SHIFT} - {{CD{1'b0}}, 1'b1};
      if (glow_clr)
        chan_val[c] = '0;
      else if (scaled[c] >= glow_q[c] || decay[c][CD] || decay[c][CD-1:0] < scaled[c])
        chan_val[c] = scaled[c];
      else
        chan_val[c] = decay[c][CD-1:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      for (int c = 0; c < 3; c++) glow_q[c] <= '0;
    end else if (ce_pix) begin
      for (int c = 0; c < 3; c++) glow_q[c] <= chan_val[c];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < 3; c++) chan_val[c] = scaled[c];
  end
`endif

  always_comb begin
    for (int c = 0; c < 3; c++)
      color_d[c] = s1_blank ? '0 : CD'(shade(SHADE_W'(chan_val[c]), line_mode));
  end

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
      blank_out <= 1'b0;
    end else if (ce_pix) begin
      r_out     <= color_d[0];
      g_out     <= color_d[1];
      b_out     <= color_d[2];
      hs_out    <= s1_hs;
      vs_out    <= s1_vs;
      blank_out <= s1_blank;
    end
  end

endmodule
